// File: rtl/fetch_request_unit.sv
// Multicycle fetch/execute sequencer: owns PC and IR, drives iREN/dREN/dWEN, commits next PC; INSTR_COUNT_EN adds a retired counter.
// Latency: 2 cycles per ALU/branch instruction, 3 per load/store with zero-wait memory.
// Backpressure: stalls in IFETCH until ihit and in DMEM until dhit; HALT holds until nRST.
module fetch_request_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        dhit,
  input  logic [2:0]  PCSrc,
  input  logic        Jump,
  input  logic [31:0] rs_data,
  input  logic [31:0] imm_ext,
  input  logic [25:0] immediate26,
  input  logic        dREN_req,
  input  logic        dWEN_req,
  input  logic        halt_req,
  output logic [31:0] imemaddr,
  output logic        iREN,
  output logic [31:0] instruction,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] pc_plus4,
  output logic        pc_en,
  output logic        halted,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {IFETCH, EXEC, DMEM, HALT} state_t;

  state_t      state, next_state;
  logic [31:0] pc, npc_q, next_pc, pc_load;
  logic        ir_load;

  // Jump is decode-side information only; low bits of rs and top of imm never reach the PC.
  logic unused_ok;
  assign unused_ok = ^{Jump, rs_data[1:0], imm_ext[31:30]};

  assign imemaddr = pc;
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    case (PCSrc)
      3'd0:    next_pc = {rs_data[31:2], 2'b00};
      3'd1:    next_pc = {pc_plus4[31:28], immediate26, 2'b00};
      3'd2:    next_pc = pc_plus4 + {imm_ext[29:0], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

  always_comb begin
    next_state = state;
    iREN       = 1'b0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    pc_en      = 1'b0;
    halted     = 1'b0;
    ir_load    = 1'b0;
    pc_load    = npc_q;
    case (state)
      IFETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          ir_load    = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (halt_req) begin
          next_state = HALT;
        end else if (dREN_req || dWEN_req) begin
          next_state = DMEM;
        end else begin
          pc_en      = 1'b1;
          pc_load    = next_pc;
          next_state = IFETCH;
        end
      end
      DMEM: begin
        // A store wins when decode raises both requests.
        dWEN = dWEN_req;
        dREN = dREN_req & ~dWEN_req;
        if (dhit) begin
          pc_en      = 1'b1;
          next_state = IFETCH;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: next_state = IFETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IFETCH;
      pc          <= PC_INIT;
      instruction <= 32'd0;
      npc_q       <= 32'd0;
    end else begin
      state <= next_state;
      if (ir_load)
        instruction <= imemload;
      if (state == EXEC)
        npc_q <= next_pc;
      if (pc_en)
        pc <= pc_load;
    end
  end

`ifdef INSTR_COUNT_EN
  logic [31:0] count_q;

  // HALT retires as an instruction even though it never commits a PC.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      count_q <= 32'd0;
    else if (pc_en || (state == EXEC && halt_req))
      count_q <= count_q + 32'd1;
  end

  assign instr_count = count_q;
`else
  assign instr_count = 32'd0;
`endif

endmodule
